// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction-fetch stage with one outstanding imem read,
//            a one-entry skid buffer and EX-driven redirect/flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [63:0] redirect_order,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc_rdata,
  output logic [31:0] if_pc_wdata,
  output logic [63:0] if_order
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] C_WORD_MASK = 32'hffff_fffc;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_issue;

  logic [31:0] r_pc;
  logic [63:0] r_order;

  logic        r_skid_valid;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;
  logic [63:0] r_skid_order;

  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc_rdata;
  logic [31:0] r_if_pc_wdata;
  logic [63:0] r_if_order;

  logic        w_can_load;
  logic        w_deliver;
  logic [31:0] w_pc_inc;
  logic [31:0] w_skid_pc_inc;

  assign w_can_load    = !id_stall || !r_if_valid;
  assign w_deliver     = (r_state == S_WAIT) && imem_resp && !redirect_valid;
  assign w_pc_inc      = r_pc + 32'd4;
  assign w_skid_pc_inc = r_skid_pc + 32'd4;

  assign imem_addr   = r_pc;
  assign imem_rmask  = w_issue ? 4'hf : 4'h0;
  assign if_valid    = r_if_valid;
  assign if_inst     = r_if_inst;
  assign if_pc_rdata = r_if_pc_rdata;
  assign if_pc_wdata = r_if_pc_wdata;
  assign if_order    = r_if_order;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A redirect racing a response in WAIT/DISCARD consumes that response,
  // so no drop is owed afterwards.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_REQ: begin
        if (rst_n && !r_skid_valid && !redirect_valid) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp) begin
          w_state_nxt = S_REQ;
        end else if (redirect_valid) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_resp) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_order       <= 64'd0;
      r_skid_valid  <= 1'b0;
      r_skid_inst   <= 32'd0;
      r_skid_pc     <= 32'd0;
      r_skid_order  <= 64'd0;
      r_if_valid    <= 1'b0;
      r_if_inst     <= 32'd0;
      r_if_pc_rdata <= 32'd0;
      r_if_pc_wdata <= 32'd0;
      r_if_order    <= 64'd0;
    end else if (redirect_valid) begin
      r_pc         <= redirect_pc & C_WORD_MASK;
      r_order      <= redirect_order;
      r_if_valid   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      // Skid full implies REQ with no request issued, so drain and deliver
      // never coincide.
      if (r_skid_valid && w_can_load) begin
        r_if_valid    <= 1'b1;
        r_if_inst     <= r_skid_inst;
        r_if_pc_rdata <= r_skid_pc;
        r_if_pc_wdata <= w_skid_pc_inc;
        r_if_order    <= r_skid_order;
        r_skid_valid  <= 1'b0;
      end else if (w_deliver) begin
        if (w_can_load) begin
          r_if_valid    <= 1'b1;
          r_if_inst     <= imem_rdata;
          r_if_pc_rdata <= r_pc;
          r_if_pc_wdata <= w_pc_inc;
          r_if_order    <= r_order;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_inst  <= imem_rdata;
          r_skid_pc    <= r_pc;
          r_skid_order <= r_order;
        end
        r_order <= r_order + 64'd1;
      end else if (!id_stall) begin
        r_if_valid <= 1'b0;
      end

      if (w_deliver) begin
        r_pc <= w_pc_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage: directed scenarios followed
//            by randomized stall/redirect/latency traffic against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h1eceb000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [63:0] redirect_order;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc_rdata;
  logic [31:0] if_pc_wdata;
  logic [63:0] if_order;

  fetch_stage #(.RESET_PC(C_RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_order (redirect_order),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc_rdata    (if_pc_rdata),
    .if_pc_wdata    (if_pc_wdata),
    .if_order       (if_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instructions owed to the decoder, oldest first.
  // Element 0 is what IF/ID must show; a second element sits in the skid.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] ord;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_pc;
  logic [63:0] exp_ord;
  logic [31:0] m_req_pc;
  bit          outst;
  bit          stale;
  int          cnt;
  int          fixed_lat;
  bit          fixed_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input bit resp_in_reset);
    rst_n          = 1'b0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    redirect_order = 64'd0;
    imem_resp      = resp_in_reset;
    imem_rdata     = $urandom;
    #1;
    check("rmask_in_reset", {60'd0, imem_rmask}, 64'd0);
    @(posedge clk);
    #1;
    imem_resp = 1'b0;
    @(negedge clk);
    #1;
    check("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check("rst_if_inst", {32'd0, if_inst}, 64'd0);
    check("rst_pc_rdata", {32'd0, if_pc_rdata}, 64'd0);
    check("rst_pc_wdata", {32'd0, if_pc_wdata}, 64'd0);
    check("rst_order", if_order, 64'd0);
    rst_n   = 1'b1;
    q.delete();
    exp_pc  = C_RESET_PC;
    exp_ord = 64'd0;
    outst   = 1'b0;
    stale   = 1'b0;
    cnt     = 0;
  endtask

  // One clock cycle: drive inputs, check registered view and request,
  // then advance the model across the rising edge.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input logic [63:0] rord);
    ent_t        e;
    logic [31:0] wd;
    logic [3:0]  exp_mask;
    id_stall       = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    redirect_order = rord;
    imem_resp      = 1'b0;
    imem_rdata     = $urandom;
    if (outst) begin
      cnt--;
      if (cnt == 0) begin
        imem_resp = 1'b1;
        if (fixed_data) imem_rdata = 32'h00000013;
      end
    end
    #1;
    if (q.size() == 0) begin
      check("if_valid_idle", {63'd0, if_valid}, 64'd0);
    end else begin
      wd = q[0].pc + 32'd4;
      check("if_valid", {63'd0, if_valid}, 64'd1);
      check("if_inst", {32'd0, if_inst}, {32'd0, q[0].inst});
      check("if_pc_rdata", {32'd0, if_pc_rdata}, {32'd0, q[0].pc});
      check("if_pc_wdata", {32'd0, if_pc_wdata}, {32'd0, wd});
      check("if_order", if_order, q[0].ord);
    end
    exp_mask = (!outst && q.size() < 2 && !rd) ? 4'hf : 4'h0;
    check("imem_rmask", {60'd0, imem_rmask}, {60'd0, exp_mask});
    if (imem_rmask == 4'hf) begin
      check("imem_addr", {32'd0, imem_addr}, {32'd0, exp_pc});
    end

    if (q.size() > 0 && !st) void'(q.pop_front());
    if (imem_resp) begin
      outst = 1'b0;
      if (!stale && !rd) begin
        e.inst = imem_rdata;
        e.pc   = m_req_pc;
        e.ord  = exp_ord;
        q.push_back(e);
        exp_ord = exp_ord + 64'd1;
        exp_pc  = m_req_pc + 32'd4;
      end
      stale = 1'b0;
    end
    if (imem_rmask == 4'hf) begin
      outst    = 1'b1;
      stale    = 1'b0;
      m_req_pc = exp_pc;
      cnt      = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
    end
    if (rd) begin
      q.delete();
      exp_pc  = rpc & 32'hffff_fffc;
      exp_ord = rord;
      if (outst) stale = 1'b1;
    end

    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_resp      = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 64'd0);
  endtask

  // Fill IF/ID with the reset-PC word and the skid with the next one.
  task automatic build_full_skid();
    step(1'b0, 1'b0, 32'd0, 64'd0);
    step(1'b0, 1'b0, 32'd0, 64'd0);
    step(1'b1, 1'b0, 32'd0, 64'd0);
    step(1'b1, 1'b0, 32'd0, 64'd0);
    step(1'b1, 1'b0, 32'd0, 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_resp      = 1'b0;
    imem_rdata     = 32'd0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    redirect_order = 64'd0;
    fixed_lat      = 1;
    fixed_data     = 1'b1;
    @(negedge clk);

    // Straight-line fetch, k=1, nop words
    do_reset(1'b0);
    #1;
    check("first_addr", {32'd0, imem_addr}, {32'd0, C_RESET_PC});
    idle(12);

    // Stall with response landing in the skid
    do_reset(1'b0);
    build_full_skid();
    step(1'b0, 1'b0, 32'd0, 64'd0);
    #1;
    check("drain_pc", {32'd0, if_pc_rdata}, 64'h1eceb004);
    check("drain_order", if_order, 64'd1);
    check("after_drain_req", {60'd0, imem_rmask}, 64'hf);
    check("after_drain_addr", {32'd0, imem_addr}, 64'h1eceb008);
    idle(6);

    // Redirect in WAIT, response two cycles later is discarded
    do_reset(1'b0);
    fixed_lat = 3;
    step(1'b0, 1'b0, 32'd0, 64'd0);
    step(1'b0, 1'b1, 32'h1eceb100, 64'd7);
    #1;
    check("redir_flush_valid", {63'd0, if_valid}, 64'd0);
    step(1'b0, 1'b0, 32'd0, 64'd0);
    step(1'b0, 1'b0, 32'd0, 64'd0);
    #1;
    check("redir_req_addr", {32'd0, imem_addr}, 64'h1eceb100);
    check("redir_req_mask", {60'd0, imem_rmask}, 64'hf);
    fixed_lat = 1;
    step(1'b0, 1'b0, 32'd0, 64'd0);
    step(1'b0, 1'b0, 32'd0, 64'd0);
    #1;
    check("redir_order", if_order, 64'd7);
    check("redir_pc", {32'd0, if_pc_rdata}, 64'h1eceb100);
    idle(4);

    // Redirect coinciding with the response: no discard state
    do_reset(1'b0);
    step(1'b0, 1'b0, 32'd0, 64'd0);
    step(1'b0, 1'b1, 32'h1eceb200, 64'd20);
    #1;
    check("same_cycle_valid", {63'd0, if_valid}, 64'd0);
    check("same_cycle_mask", {60'd0, imem_rmask}, 64'hf);
    check("same_cycle_addr", {32'd0, imem_addr}, 64'h1eceb200);
    idle(4);

    // Redirect while stalled with full skid, to a misaligned wrap target
    do_reset(1'b0);
    build_full_skid();
    step(1'b1, 1'b1, 32'hfffffffe, 64'hffff_ffff_ffff_ffff);
    #1;
    check("skid_flush_valid", {63'd0, if_valid}, 64'd0);
    check("wrap_addr", {32'd0, imem_addr}, 64'hfffffffc);
    step(1'b0, 1'b0, 32'd0, 64'd0);
    step(1'b0, 1'b0, 32'd0, 64'd0);
    #1;
    check("wrap_pc_wdata", {32'd0, if_pc_wdata}, 64'd0);
    check("wrap_order", if_order, 64'hffff_ffff_ffff_ffff);
    idle(6);

    // Reset in the middle of WAIT with the response in the reset cycle
    fixed_lat = 3;
    step(1'b0, 1'b0, 32'd0, 64'd0);
    step(1'b0, 1'b0, 32'd0, 64'd0);
    do_reset(1'b1);
    idle(6);

    // Randomized traffic
    fixed_lat  = 0;
    fixed_data = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit          st;
      bit          rd;
      logic [63:0] ro;
      st = ($urandom_range(0, 99) < 35);
      rd = ($urandom_range(0, 99) < 6);
      ro = ($urandom_range(0, 3) == 0) ? 64'hffff_ffff_ffff_fffe : {$urandom, $urandom};
      step(st, rd, $urandom, ro);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
